button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Cleans a raw asynchronous pushbutton into a stable, clock-synchronous level.
//   Sits directly upstream of the rising-edge detector; db_out drives that
//   block's w input, so each physical press yields exactly one z pulse.
//   Consists of a 2-FF synchroniser followed by a counter-qualified 4-state FSM.
// PARAMETERS
//   CNT_MAX  4  consecutive stable cycles required before db_out changes (>=1)
//   CNT_W    $clog2(CNT_MAX)+1  width of the stability counter
// PORTS
//   clk     in   1      single system clock; all flops update on its rising edge
//   rst     in   1      synchronous, active-low reset (sampled on rising clk edge)
//   btn_in  in   1      raw button, asynchronous to clk, may bounce
//   db_out  out  1      debounced level (registered); feeds edge detector w
//   busy    out  1      1 while a candidate transition is being qualified
// BEHAVIOUR
//   Reset (rst==0 at a clk edge): sync1=sync2=0, cnt=0, state=LOW, db_out=0,
//     busy=0. Reset wins over all other activity, including mid-qualification.
//   Synchroniser: sync1<=btn_in; sync2<=sync1. The FSM sees only sync2.
//   FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
//     LOW:       sync2==1 -> WAIT_HIGH, cnt<=0; else stay.
//     WAIT_HIGH: sync2==0 -> LOW, cnt<=0 (bounce rejected);
//                sync2==1 && cnt==CNT_MAX-1 -> HIGH, db_out<=1, cnt<=0;
//                sync2==1 otherwise -> cnt<=cnt+1.
//     HIGH:      sync2==0 -> WAIT_LOW, cnt<=0; else stay.
//     WAIT_LOW:  mirror of WAIT_HIGH (sync2==1 aborts to HIGH; the qualifying
//                count leads to LOW with db_out<=0).
//     Illegal or unused encoding -> LOW, db_out<=0.
//   db_out is a flop written only on WAIT->stable transitions; it never glitches.
//   busy = (state==WAIT_HIGH || state==WAIT_LOW), decoded from the state register.
//   Latency: if btn_in settles before clk edge k and stays stable, sync2 holds it
//     after edge k+1, the FSM enters WAIT after edge k+2, and db_out updates after
//     edge k+2+CNT_MAX. Total latency is CNT_MAX+2 cycles.
//   Any reversal of sync2 during WAIT restarts qualification from scratch.
//     The counter never saturates or wraps: it is cleared on every exit.
//   A pulse shorter than CNT_MAX cycles after synchronisation never reaches db_out.
//   Counter arithmetic is unsigned CNT_W bits; the compare is exact equality with CNT_MAX-1.
// STRUCTURE
//   Shared include debounce_defs.vh: 2-bit state encodings LOW=00, WAIT_HIGH=01,
//     HIGH=10, WAIT_LOW=11, plus the default CNT_MAX for simulation and synthesis.
//   One sub-module, sync_2ff (clk, rst, d, q), reused for other async inputs.
//   Top level holds the FSM, counter and db_out register.
// TESTING  (CNT_MAX=4 unless stated)
//   1. rst=0 for 2 cycles with btn_in=1 -> db_out=0, busy=0, state=LOW throughout.
//   2. Clean press: btn_in 0->1 held 10 cycles -> db_out rises exactly 6 edges later.
//      busy is high for 4 cycles. The downstream edge detector gives a single z pulse.
//   3. Bounce: btn_in toggles 1,0,1,0 every 2 cycles, then holds 1 -> db_out stays 0
//      until 6 edges after the final rise; busy drops on each reversal.
//   4. Release: from HIGH, btn_in 1->0 held -> db_out falls 6 edges later. A 3-cycle
//      low glitch leaves db_out at 1.
//   5. Reset during WAIT_HIGH at cnt=2 -> next edge state=LOW, cnt=0, db_out=0, busy=0.
//      A later clean press qualifies normally.
//   6. CNT_MAX=1: step on btn_in -> db_out follows 3 edges later. A 1-cycle pulse
//      aligned to a clk edge is rejected.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encodings and
// the default stability count used by simulation and synthesis builds.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b10,
    ST_WAIT_LOW  = 2'b11
  } state_t;

  localparam int DEFAULT_CNT_MAX = 4;

  // One extra bit so CNT_MAX-1 always fits, even for CNT_MAX == 1.
  function automatic int cnt_width(input int cnt_max);
    return $clog2(cnt_max) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; q lags d by two
// rising clk edges and both stages clear on a synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_reg;
  logic sync2_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= d;
      sync2_reg <= sync1_reg;
    end
  end

  assign q = sync2_reg;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: synchronises btn_in, then only lets db_out change
// after the synchronised level has held for CNT_MAX consecutive cycles.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int CNT_MAX = DEFAULT_CNT_MAX,
  parameter int CNT_W   = cnt_width(CNT_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic db_out,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync2;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             db_out_reg;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync2)
  );

  // Any reversal during a WAIT state returns to the old stable state with the
  // counter cleared, so qualification always restarts from zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_LOW;
      cnt_reg    <= '0;
      db_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOW: begin
          if (sync2) begin
            state_reg <= ST_WAIT_HIGH;
            cnt_reg   <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync2) begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= ST_HIGH;
            db_out_reg <= 1'b1;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!sync2) begin
            state_reg <= ST_WAIT_LOW;
            cnt_reg   <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (sync2) begin
            state_reg <= ST_HIGH;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= ST_LOW;
            db_out_reg <= 1'b0;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg  <= ST_LOW;
          cnt_reg    <= '0;
          db_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign db_out = db_out_reg;
  assign busy   = (state_reg == ST_WAIT_HIGH) || (state_reg == ST_WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: one instance at CNT_MAX=4 and one at
// CNT_MAX=1, with expected levels computed by hand from the latency rules.
module tb_button_debouncer;
  import button_debouncer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_a = 1'b0;
  logic btn_b = 1'b0;
  logic db_a, busy_a, db_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_debouncer #(.CNT_MAX(4)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_a),
    .db_out (db_a),
    .busy   (busy_a)
  );

  button_debouncer #(.CNT_MAX(1)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_b),
    .db_out (db_b),
    .busy   (busy_b)
  );

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step btn to lvl before edge j=0, then check 10 edges: busy during
  // j=2..lat+1, db_out flips after edge lat+2; counts z pulses downstream.
  task automatic qualify(input bit sel_b, input logic lvl, input int lat, input string tag);
    logic db, bz, db_prev, exp_db, exp_bz;
    int   z_cnt;
    z_cnt   = 0;
    db_prev = sel_b ? db_b : db_a;
    if (sel_b) btn_b = lvl; else btn_a = lvl;
    for (int j = 0; j < 10; j++) begin
      tick();
      db = sel_b ? db_b : db_a;
      bz = sel_b ? busy_b : busy_a;
      exp_db = (j >= lat + 2) ? lvl : ~lvl;
      exp_bz = (j >= 2) && (j < lat + 2);
      check_eq($sformatf("%s_db_j%0d", tag, j), {3'b0, db}, {3'b0, exp_db});
      check_eq($sformatf("%s_busy_j%0d", tag, j), {3'b0, bz}, {3'b0, exp_bz});
      if (db && !db_prev) z_cnt++;
      db_prev = db;
    end
    check_eq({tag, "_zpulses"}, 4'(z_cnt), lvl ? 4'd1 : 4'd0);
    $display("txn %s: btn=%0b latency=%0d edges", tag, lvl, lat + 2);
  endtask

  logic bounce_v [0:17];

  initial begin
    // Reset held with btn high: nothing may leave LOW.
    rst   = 1'b0;
    btn_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst_db", {3'b0, db_a}, 4'd0);
      check_eq("rst_busy", {3'b0, busy_a}, 4'd0);
      check_eq("rst_state", {2'b0, dut_a.state_reg}, {2'b0, ST_LOW});
    end
    $display("txn reset: 2 cycles with btn=1");
    btn_a = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    qualify(1'b0, 1'b1, 4, "press");

    // 3-cycle low glitch while HIGH never reaches db_out.
    btn_a = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    btn_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("glitch_db_%0d", i), {3'b0, db_a}, 4'd1);
    end
    $display("txn glitch: 3-cycle low pulse");

    qualify(1'b0, 1'b0, 4, "release");
    for (int i = 0; i < 3; i++) tick();

    // Bounce 1,1,0,0,1,1,0,0 then hold 1; final rise stable from edge 8.
    for (int t = 0; t < 18; t++) bounce_v[t] = (t >= 8) || ((t % 4) < 2);
    for (int t = 0; t < 18; t++) begin
      logic exp_bz;
      btn_a = bounce_v[t];
      tick();
      exp_bz = (t == 2) || (t == 3) || (t == 6) || (t == 7) || (t >= 10 && t <= 13);
      check_eq($sformatf("bounce_db_e%0d", t), {3'b0, db_a}, (t >= 14) ? 4'd1 : 4'd0);
      check_eq($sformatf("bounce_busy_e%0d", t), {3'b0, busy_a}, {3'b0, exp_bz});
    end
    $display("txn bounce: 1,0,1,0 every 2 cycles then hold");

    qualify(1'b0, 1'b0, 4, "release2");
    for (int i = 0; i < 3; i++) tick();

    // Reset in WAIT_HIGH with cnt=2.
    btn_a = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    check_eq("midq_state", {2'b0, dut_a.state_reg}, {2'b0, ST_WAIT_HIGH});
    check_eq("midq_cnt", 4'(dut_a.cnt_reg), 4'd2);
    rst   = 1'b0;
    btn_a = 1'b0;
    tick();
    check_eq("midrst_state", {2'b0, dut_a.state_reg}, {2'b0, ST_LOW});
    check_eq("midrst_cnt", 4'(dut_a.cnt_reg), 4'd0);
    check_eq("midrst_db", {3'b0, db_a}, 4'd0);
    check_eq("midrst_busy", {3'b0, busy_a}, 4'd0);
    $display("txn midrst: reset during WAIT_HIGH");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    qualify(1'b0, 1'b1, 4, "press2");

    // CNT_MAX=1 instance: single-cycle pulse rejected, then step follows.
    btn_b = 1'b1;
    tick();
    btn_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("b_pulse_db_%0d", i), {3'b0, db_b}, 4'd0);
    end
    $display("txn b_pulse: 1-cycle pulse on CNT_MAX=1");
    qualify(1'b1, 1'b1, 1, "b_rise");
    qualify(1'b1, 1'b0, 1, "b_fall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
